// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - runtime-loadable serial pattern detector with saturating match counter
module seq_det_param #(
    parameter int                 PAT_LEN = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [PAT_LEN-1:0] RST_PAT = 4'b1011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               load_pat,
    input  logic               overlap_en,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat,
    input  logic               cnt_clr
);

    localparam int               FW        = $clog2(PAT_LEN);
    localparam logic [FW-1:0]    FILL_LAST = FW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {FILL, ARMED} state_t;

    state_t             state, state_next;
    logic [FW-1:0]      fill, fill_next;
    logic [PAT_LEN-1:0] history, hist_next;
    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-1:0] shifted;
    logic               match;

    assign shifted = {history[PAT_LEN-2:0], in};

    always_comb begin
        state_next = state;
        fill_next  = fill;
        hist_next  = history;
        match      = 1'b0;
        if (load_pat) begin
            // a bit arriving with a load belongs to neither the old nor the new pattern
            state_next = FILL;
            fill_next  = '0;
            hist_next  = '0;
        end else if (in_valid) begin
            hist_next = shifted;
            case (state)
                FILL: begin
                    if (fill == FILL_LAST) begin
                        state_next = ARMED;
                        match      = (shifted == pat_reg);
                    end else begin
                        fill_next = fill + FW'(1);
                    end
                end
                ARMED: match = (shifted == pat_reg);
                default: state_next = FILL;
            endcase
            if (match && !overlap_en) begin
                state_next = FILL;
                fill_next  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            fill      <= '0;
            history   <= '0;
            pat_reg   <= RST_PAT;
            out       <= 1'b0;
            match_cnt <= '0;
        end else begin
            state   <= state_next;
            fill    <= fill_next;
            history <= hist_next;
            out     <= match;
            if (load_pat) begin
                pat_reg <= pattern;
            end
            // clear wins over the old count but still records a coincident match
            if (cnt_clr) begin
                match_cnt <= match ? CNT_W'(1) : '0;
            end else if (match && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

    assign cnt_sat = (match_cnt == CNT_MAX);

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial pattern detector, the successor to the fixed-sequence seq_gen detector. It samples one bit per valid cycle and compares the last PAT_LEN bits against a runtime-loadable pattern. It pulses out on each match and keeps a saturating match counter. Overlapping and non-overlapping detection are selected at runtime. It sits on serial control/data lines, feeding status logic or interrupt aggregation.

Parameters:
PAT_LEN, 4, pattern length in bits (legal 2..16)
CNT_W, 8, width of the match counter
RST_PAT, 4'b1011, pattern loaded at reset (PAT_LEN bits wide)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in  input  1  serial data bit
in_valid  input  1  in is sampled only when high
pattern  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit received
load_pat  input  1  capture pattern on this edge
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
out  output  1  one-cycle match pulse
match_cnt  output  CNT_W  number of matches since reset/clear
cnt_sat  output  1  high while match_cnt is at all-ones
cnt_clr  input  1  synchronous clear of match_cnt and cnt_sat

Behaviour:
- Reset (reset=1 at a rising edge):
  - pat_reg=RST_PAT, history=0, fill=0, state=FILL.
  - out=0, match_cnt=0, cnt_sat=0.
  - Reset overrides every other input.
- State machine, two states:
  - FILL: fewer than PAT_LEN valid bits held since the last reset/load/non-overlap match.
  - ARMED: history holds PAT_LEN valid bits.
  - FILL->ARMED when fill reaches PAT_LEN-1 and a valid bit arrives.
  - ARMED->FILL on load_pat, or on a match with overlap_en=0.
- Sampling: on an edge with in_valid=1, history <= {history[PAT_LEN-2:0], in}. In FILL, fill increments.
- Match condition: the post-shift history equals pat_reg, evaluated on a valid edge that lands in or stays in ARMED. The bit that completes the first fill counts.
- Match latency:
  - out goes high for exactly one cycle, starting the cycle after the edge that sampled the completing bit (registered output).
  - match_cnt increments on that same edge.
  - out=0 on every cycle without a match, including cycles with in_valid=0.
- Overlap mode:
  - overlap_en=1: history is kept after a match, so the next match may share bits.
  - overlap_en=0: after a match, fill=0 and state=FILL, so the next match needs PAT_LEN fresh bits.
  - overlap_en is sampled on the matching edge. Changing it mid-stream has no other effect.
- load_pat:
  - pat_reg<=pattern, history=0, fill=0, state=FILL.
  - If in_valid is also high on that edge, the bit is discarded and no match is evaluated.
  - out=0 on the following cycle.
- Counter:
  - match_cnt saturates at 2^CNT_W-1. Further matches still pulse out but do not wrap.
  - cnt_sat=1 whenever match_cnt is all-ones.
  - cnt_clr zeroes match_cnt and cnt_sat. When it coincides with a match, the result is match_cnt=1 and out still pulses.
- in_valid=0 edges: no shift, no state change, no match.

Test Plan:
- Reset, then overlap_en=1 and stream 1,0,1,1,0,1,1 (in_valid=1) -> out pulses after the 4th and 7th bits; match_cnt=2.
- Same stream with overlap_en=0 -> single pulse after the 4th bit; match_cnt=1.
- load_pat with pattern=4'b0110 while in_valid=1, then stream 0,1,1,0,1,1,0 with overlap_en=1 -> pulses after the 4th and 7th post-load bits; the load-cycle bit is ignored.
- 1,0,1,1 with in_valid deasserted for 3 cycles between each bit -> exactly one pulse, one cycle after the final 1 is sampled.
- CNT_W=2, 5 overlapping matches of 1011 -> match_cnt sequence 1,2,3,3,3; cnt_sat high from the 3rd match; cnt_clr together with the 6th match -> match_cnt=1, cnt_sat=0.
- Reset asserted mid-pattern after 1,0,1, then 1 -> no pulse; match_cnt=0; a full 1,0,1,1 afterwards -> one pulse.
